// File: rtl/paper_cpu_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the 2-bit paper processor.
// Every output is registered from the next-state decode, so outputs line up with the state they belong to.
module paper_cpu_ctrl #(
   parameter int              PC_W     = 4,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            step,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_rd,
   input  logic [7:0]      imem_data,
   input  logic [1:0]      dp_q,
   output logic            dp_a1,
   output logic            dp_a0,
   output logic            dp_s,
   output logic            dp_en,
   output logic            busy,
   output logic            halted
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [1:0]      OP_NOP  = 2'b00;
   localparam logic [1:0]      OP_DP   = 2'b01;
   localparam logic [1:0]      OP_JMP  = 2'b10;
   localparam logic [1:0]      OP_HALT = 2'b11;
   localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state_r, state_s;
   logic [PC_W-1:0] pc_r, pc_s;
   logic [7:0]      ir_r, ir_s;
   logic            step_latched_r, step_latched_s;
   logic [PC_W-1:0] pc_inc_s, jmp_tgt_s;
   logic            dp_a1_s, dp_a0_s, dp_s_s, dp_en_s;
   logic            imem_rd_r, busy_r, halted_r;
   logic            dp_a1_r, dp_a0_r, dp_s_r, dp_en_r;

   assign pc_inc_s  = pc_r + PC_ONE;
   assign jmp_tgt_s = ir_r[PC_W-1:0];

   // Next-state, PC/IR update and next-cycle datapath control decode
   always_comb begin
      state_s        = state_r;
      pc_s           = pc_r;
      ir_s           = ir_r;
      step_latched_s = step_latched_r;
      dp_a1_s        = 1'b0;
      dp_a0_s        = 1'b0;
      dp_s_s         = 1'b0;
      dp_en_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (run) begin
               state_s        = ST_FETCH;
               step_latched_s = 1'b0;
            end else if (step) begin
               state_s        = ST_FETCH;
               step_latched_s = 1'b1;
            end else begin
               state_s        = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_s = ST_DECODE;
         end
         ST_DECODE: begin
            ir_s    = imem_data;
            state_s = ST_EXEC;
            // DP controls are prepared here so the registered pulse lands exactly on EXEC
            if (imem_data[7:6] == OP_DP) begin
               dp_a1_s = imem_data[5];
               dp_a0_s = imem_data[4];
               dp_s_s  = imem_data[0];
               dp_en_s = 1'b1;
            end else begin
               dp_en_s = 1'b0;
            end
         end
         ST_EXEC: begin
            case (ir_r[7:6])
               OP_NOP:  pc_s = pc_inc_s;
               OP_DP:   pc_s = pc_inc_s;
               OP_JMP: begin
                  case (ir_r[5:4])
                     2'b00:   pc_s = (dp_q == 2'b00) ? jmp_tgt_s : pc_inc_s;
                     2'b01:   pc_s = jmp_tgt_s;
                     default: pc_s = pc_inc_s;
                  endcase
               end
               OP_HALT: pc_s = pc_r;
               default: pc_s = pc_r;
            endcase
            if (ir_r[7:6] == OP_HALT) begin
               state_s        = ST_HALT;
               step_latched_s = 1'b0;
            end else if (step_latched_r || !run) begin
               state_s        = ST_IDLE;
               step_latched_s = 1'b0;
            end else begin
               state_s        = ST_FETCH;
            end
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s        = ST_IDLE;
            pc_s           = RESET_PC;
            ir_s           = 8'h00;
            step_latched_s = 1'b0;
         end
      endcase
   end

   // State, PC, IR and registered output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         pc_r           <= RESET_PC;
         ir_r           <= 8'h00;
         step_latched_r <= 1'b0;
         imem_rd_r      <= 1'b0;
         busy_r         <= 1'b0;
         halted_r       <= 1'b0;
         dp_a1_r        <= 1'b0;
         dp_a0_r        <= 1'b0;
         dp_s_r         <= 1'b0;
         dp_en_r        <= 1'b0;
      end else begin
         state_r        <= state_s;
         pc_r           <= pc_s;
         ir_r           <= ir_s;
         step_latched_r <= step_latched_s;
         imem_rd_r      <= (state_s == ST_FETCH);
         busy_r         <= (state_s == ST_FETCH) || (state_s == ST_DECODE) ||
                           (state_s == ST_EXEC);
         halted_r       <= (state_s == ST_HALT);
         dp_a1_r        <= dp_a1_s;
         dp_a0_r        <= dp_a0_s;
         dp_s_r         <= dp_s_s;
         dp_en_r        <= dp_en_s;
      end
   end

   assign imem_addr = pc_r;
   assign imem_rd   = imem_rd_r;
   assign busy      = busy_r;
   assign halted    = halted_r;
   assign dp_a1     = dp_a1_r;
   assign dp_a0     = dp_a0_r;
   assign dp_s      = dp_s_r;
   assign dp_en     = dp_en_r;

endmodule

// File: tb/tb_paper_cpu_ctrl.sv
// Self-checking bench for paper_cpu_ctrl: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_paper_cpu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, run, step;
   logic [3:0] imem_addr;
   logic       imem_rd;
   logic [7:0] imem_data;
   logic [1:0] dp_q;
   logic       dp_a1, dp_a0, dp_s, dp_en, busy, halted;
   logic [7:0] rom [0:15];
   int         n_tests = 0;
   int         n_fail  = 0;

   paper_cpu_ctrl #(.PC_W(4), .RESET_PC(4'd0)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step),
      .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
      .dp_q(dp_q), .dp_a1(dp_a1), .dp_a0(dp_a0), .dp_s(dp_s), .dp_en(dp_en),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   // synchronous ROM: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (imem_rd === 1'b1) imem_data <= rom[imem_addr];
   end

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; step = 1'b0; dp_q = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask

   task automatic wait_fetch(output logic [3:0] addr, output bit ok);
      ok = 1'b0; addr = 4'd0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (imem_rd === 1'b1) begin ok = 1'b1; addr = imem_addr; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++;
      if ({busy, halted, imem_rd, dp_en, dp_a1, dp_a0, dp_s, imem_addr} !== 11'd0) begin
         n_fail++; $display("FAIL reset_idle: got %h expected 000", {busy, halted, imem_rd, dp_en, dp_a1, dp_a0, dp_s, imem_addr});
      end
      clear_rom(); rom[0] = 8'h95; rom[5] = 8'h51; run = 1'b1;
      repeat (6) @(negedge clk);
      n_tests++;
      if ({dp_en, busy, imem_addr} !== {1'b1, 1'b1, 4'd5}) begin
         n_fail++; $display("FAIL reset_pre_exec: got %b expected 115", {dp_en, busy, imem_addr});
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, halted, imem_rd, dp_en, dp_a1, dp_a0, dp_s, imem_addr} !== 11'd0) begin
         n_fail++; $display("FAIL reset_async: got %h expected 000", {busy, halted, imem_rd, dp_en, dp_a1, dp_a0, dp_s, imem_addr});
      end
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy, imem_rd, imem_addr} !== 6'd0) begin
         n_fail++; $display("FAIL reset_release: got %b expected 0", {busy, imem_rd, imem_addr});
      end
   endtask

   task automatic test_free_run();
      int pulses, pulse_cyc, halt_cyc;
      logic [2:0] pulse_val;
      pulses = 0; pulse_cyc = 0; halt_cyc = 0; pulse_val = 3'b000;
      do_reset(); clear_rom();
      rom[0] = 8'h51; rom[1] = 8'h00; rom[2] = 8'hC0;
      run = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (dp_en === 1'b1) begin pulses++; pulse_cyc = c; pulse_val = {dp_a1, dp_a0, dp_s}; end
         if (halted === 1'b1 && halt_cyc == 0) halt_cyc = c;
      end
      n_tests++;
      if (pulses != 1 || pulse_cyc != 3 || pulse_val !== 3'b011) begin
         n_fail++; $display("FAIL free_run_dp: got pulses=%0d cyc=%0d val=%b expected 1/3/011", pulses, pulse_cyc, pulse_val);
      end
      n_tests++;
      if (halt_cyc != 10) begin
         n_fail++; $display("FAIL free_run_halt: got cycle %0d expected 10", halt_cyc);
      end
      n_tests++;
      if ({imem_addr, busy, imem_rd} !== {4'd2, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL free_run_pc: got %b expected 001000", {imem_addr, busy, imem_rd});
      end
      run = 1'b0;
   endtask

   task automatic test_branch();
      logic [7:0] ins [3];
      logic [1:0] dq  [3];
      logic [3:0] exp_a [3];
      logic [3:0] a0, a1;
      bit ok0, ok1;
      ins = '{8'h83, 8'h83, 8'h97};
      dq  = '{2'b00, 2'b10, 2'b00};
      exp_a = '{4'd3, 4'd1, 4'd7};
      for (int i = 0; i < 3; i++) begin
         do_reset(); clear_rom();
         rom[0] = ins[i]; dp_q = dq[i]; run = 1'b1;
         wait_fetch(a0, ok0);
         wait_fetch(a1, ok1);
         n_tests++;
         if ({ok0, ok1, a0, a1} !== {1'b1, 1'b1, 4'd0, exp_a[i]}) begin
            n_fail++; $display("FAIL branch_%0d: got ok=%b%b addr=%0d,%0d expected 11 0,%0d", i, ok0, ok1, a0, a1, exp_a[i]);
         end
         run = 1'b0;
      end
   endtask

   task automatic test_step();
      int busy_cnt, dpen_cnt;
      logic [2:0] val;
      do_reset(); clear_rom();
      rom[0] = 8'h51; rom[1] = 8'h61;
      busy_cnt = 0; dpen_cnt = 0;
      step = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         step = 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (dp_en === 1'b1) dpen_cnt++;
      end
      n_tests++;
      if (busy_cnt != 3 || dpen_cnt != 1 || imem_addr !== 4'd1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL step_single: got busy=%0d dpen=%0d pc=%0d expected 3/1/1", busy_cnt, dpen_cnt, imem_addr);
      end
      busy_cnt = 0; dpen_cnt = 0; val = 3'b000;
      step = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         step = (c == 1 || c == 3) ? 1'b1 : 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (dp_en === 1'b1) begin dpen_cnt++; val = {dp_a1, dp_a0, dp_s}; end
      end
      n_tests++;
      if (busy_cnt != 3 || dpen_cnt != 1 || val !== 3'b101 || imem_addr !== 4'd2) begin
         n_fail++; $display("FAIL step_ignored: got busy=%0d dpen=%0d val=%b pc=%0d expected 3/1/101/2", busy_cnt, dpen_cnt, val, imem_addr);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] fa [3];
      bit ok [3];
      int rd_cnt;
      do_reset(); clear_rom();
      rom[0] = 8'h9F; run = 1'b1;
      for (int i = 0; i < 3; i++) wait_fetch(fa[i], ok[i]);
      n_tests++;
      if ({ok[0], ok[1], ok[2], fa[0], fa[1], fa[2]} !== {3'b111, 4'd0, 4'd15, 4'd0}) begin
         n_fail++; $display("FAIL wrap_fetch: got addrs %0d,%0d,%0d expected 0,15,0", fa[0], fa[1], fa[2]);
      end
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL wrap_exec_completes: got busy=%b expected 1", busy);
      end
      @(negedge clk);
      n_tests++;
      if ({busy, imem_addr} !== {1'b0, 4'd15}) begin
         n_fail++; $display("FAIL wrap_idle_pc: got busy=%b pc=%0d expected 0/15", busy, imem_addr);
      end
      rd_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (imem_rd !== 1'b0) rd_cnt++;
      end
      n_tests++;
      if (rd_cnt != 0) begin
         n_fail++; $display("FAIL wrap_stays_idle: got %0d fetches expected 0", rd_cnt);
      end
   endtask

   task automatic test_halt_lock();
      bit seen;
      do_reset(); clear_rom();
      rom[0] = 8'hC0; run = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (halted === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin
         n_fail++; $display("FAIL halt_reached: got halted=%b expected 1", halted);
      end
      for (int c = 0; c < 20; c++) begin
         run  = 1'($urandom_range(0, 1));
         step = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_tests++;
         if ({imem_rd, busy, halted, imem_addr} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL halt_lock_%0d: got rd/busy/halted/pc=%b expected 0010000", c, {imem_rd, busy, halted, imem_addr});
         end
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (halted !== 1'b0) begin
         n_fail++; $display("FAIL halt_reset: got halted=%b expected 0", halted);
      end
      run = 1'b0; step = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] w, instr;
      logic [3:0] mpc;
      logic [1:0] dq;
      logic [3:0] exp_dp;
      bit done;
      for (int p = 0; p < 6; p++) begin
         do_reset();
         for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            if (w[7:6] == 2'b11 && $urandom_range(0, 3) != 0) w[7:6] = 2'b00;
            rom[i] = w;
         end
         run = 1'b1; mpc = 4'd0; done = 1'b0;
         @(negedge clk);
         for (int k = 0; k < 30 && !done; k++) begin
            n_tests++;
            if ({imem_rd, imem_addr} !== {1'b1, mpc}) begin
               n_fail++; $display("FAIL rand_fetch p%0d i%0d: got rd=%b addr=%0d expected 1/%0d", p, k, imem_rd, imem_addr, mpc);
            end
            instr = rom[mpc];
            dq = 2'($urandom_range(0, 3));
            dp_q = dq;
            repeat (2) @(negedge clk);
            exp_dp = (instr[7:6] == 2'b01) ? {1'b1, instr[5], instr[4], instr[0]} : 4'b0000;
            n_tests++;
            if ({dp_en, dp_a1, dp_a0, dp_s} !== exp_dp) begin
               n_fail++; $display("FAIL rand_dp p%0d i%0d: got %b expected %b", p, k, {dp_en, dp_a1, dp_a0, dp_s}, exp_dp);
            end
            if (instr[7:6] == 2'b10 && instr[5:4] == 2'b01) mpc = instr[3:0];
            else if (instr[7:6] == 2'b10 && instr[5:4] == 2'b00 && dq == 2'b00) mpc = instr[3:0];
            else if (instr[7:6] != 2'b11) mpc = mpc + 4'd1;
            @(negedge clk);
            if (instr[7:6] == 2'b11) begin
               done = 1'b1;
               n_tests++;
               if ({halted, imem_rd, imem_addr} !== {1'b1, 1'b0, mpc}) begin
                  n_fail++; $display("FAIL rand_halt p%0d: got halted=%b rd=%b pc=%0d expected 1/0/%0d", p, halted, imem_rd, imem_addr, mpc);
               end
            end
         end
         run = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; step = 1'b0; dp_q = 2'b00;
      clear_rom();
      test_reset();
      test_free_run();
      test_branch();
      test_step();
      test_wrap();
      test_halt_lock();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
